// File: rtl/sg_pkg.sv
// Shared constants and FSM state type for the DAC signal-generator sequencer.
// The optional shadow bank is enabled by defining SGSEQ_SHADOW_EN.
package sg_pkg;

  localparam logic [3:0] CS_IDLE = 4'h0;
  localparam logic [3:0] CS_LOAD = 4'h5;
  localparam logic [3:0] CS_RUN  = 4'h7;

  localparam int NPTS = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN
  } seqState_t;

endpackage

// File: rtl/sig_gen_seq_if.sv
// Host-side register/command interface of the signal-generator sequencer.
// Shared by default and SGSEQ_SHADOW_EN builds.
interface sig_gen_seq_if #(
  parameter int DW = 12,
  parameter int CW = 16
);
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [DW-1:0] wr_data;
  logic          start;
  logic          stop;
  logic [CW-1:0] cycles;
  logic          wr_err;

  modport master (
    output wr_en, wr_addr, wr_data, start, stop, cycles,
    input  wr_err
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, start, stop, cycles,
    output wr_err
  );
endinterface

// File: rtl/sg_point_bank.sv
// Eight waveform point registers with write decode; with SGSEQ_SHADOW_EN defined,
// also a shadow bank whose pending contents are copied in on commit.
module sg_point_bank
  import sg_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wrEn,
  input  logic [2:0]               wrAddr,
  input  logic [DW-1:0]            wrData,
  input  logic                     wrIdle,
`ifdef SGSEQ_SHADOW_EN
  input  logic                     commit,
  output logic                     pending,
`endif
  output logic [NPTS-1:0][DW-1:0]  points
);

  for (genvar gi = 0; gi < NPTS; gi++) begin : gPoint
    logic          hit;
    logic [DW-1:0] pointReg;

    assign hit        = wrEn && (wrAddr == 3'(gi));
    assign points[gi] = pointReg;

`ifdef SGSEQ_SHADOW_EN
    logic [DW-1:0] shadowReg;
    logic [DW-1:0] shadowNext;

    // A write landing on the commit clock is merged so it is not lost.
    assign shadowNext = hit ? wrData : shadowReg;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        shadowReg <= '0;
        pointReg  <= '0;
      end else begin
        shadowReg <= shadowNext;
        if (hit && wrIdle)
          pointReg <= wrData;
        else if (commit)
          pointReg <= shadowNext;
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst)
        pointReg <= '0;
      else if (hit && wrIdle)
        pointReg <= wrData;
    end
`endif
  end

`ifdef SGSEQ_SHADOW_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      pending <= 1'b0;
    else if (commit)
      pending <= 1'b0;
    else if (wrEn && !wrIdle)
      pending <= 1'b1;
  end
`endif

endmodule

// File: rtl/sig_gen_seq.sv
// Sequencer for the 8-point DAC signal generator: point storage, IDLE/LOAD/RUN control
// and burst period counting. Define SGSEQ_SHADOW_EN for shadowed writes during a burst.
module sig_gen_seq
  import sg_pkg::*;
#(
  parameter int DW          = 12,
  parameter int CW          = 16,
  parameter int PERIOD_CLKS = 8
) (
  input  logic          clk,
  input  logic          rst,
  sig_gen_seq_if.slave  host,
  output logic [3:0]    controlstate,
  output logic [DW-1:0] sgDP0,
  output logic [DW-1:0] sgDP1,
  output logic [DW-1:0] sgDP2,
  output logic [DW-1:0] sgDP3,
  output logic [DW-1:0] sgDP4,
  output logic [DW-1:0] sgDP5,
  output logic [DW-1:0] sgDP6,
  output logic [DW-1:0] sgDP7,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] period_cnt
);

  localparam int PW = $clog2(PERIOD_CLKS);

  seqState_t             state;
  logic [PW-1:0]         phase;
  logic [CW-1:0]         cyclesLat;
  logic [NPTS-1:0][DW-1:0] points;
  logic                  idleNow;
  logic                  lastPhase;
  logic [CW:0]           cntPlus1;
  logic                  burstDone;
  logic [CW-1:0]         cntSat;
  logic                  pending;

  assign idleNow   = (state == ST_IDLE);
  assign lastPhase = (phase == PW'(PERIOD_CLKS - 1));
  // One extra bit so the completion compare cannot wrap at all-ones.
  assign cntPlus1  = {1'b0, period_cnt} + {{CW{1'b0}}, 1'b1};
  assign burstDone = (cyclesLat != '0) && (cntPlus1 == {1'b0, cyclesLat});
  assign cntSat    = (&period_cnt) ? period_cnt : cntPlus1[CW-1:0];

`ifdef SGSEQ_SHADOW_EN
  logic commit;
  assign commit      = (state == ST_RUN) && lastPhase && !host.stop && pending;
  assign host.wr_err = 1'b0;
`else
  logic wrErrReg;
  assign pending     = 1'b0;
  assign host.wr_err = wrErrReg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      wrErrReg <= 1'b0;
    else
      wrErrReg <= host.wr_en && !idleNow;
  end
`endif

  sg_point_bank #(.DW(DW)) uBank (
    .clk    (clk),
    .rst    (rst),
    .wrEn   (host.wr_en),
    .wrAddr (host.wr_addr),
    .wrData (host.wr_data),
    .wrIdle (idleNow),
`ifdef SGSEQ_SHADOW_EN
    .commit (commit),
    .pending(pending),
`endif
    .points (points)
  );

  assign sgDP0 = points[0];
  assign sgDP1 = points[1];
  assign sgDP2 = points[2];
  assign sgDP3 = points[3];
  assign sgDP4 = points[4];
  assign sgDP5 = points[5];
  assign sgDP6 = points[6];
  assign sgDP7 = points[7];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      controlstate <= CS_IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      period_cnt   <= '0;
      phase        <= '0;
      cyclesLat    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (host.start && !host.stop) begin
            state        <= ST_LOAD;
            controlstate <= CS_LOAD;
            busy         <= 1'b1;
            cyclesLat    <= host.cycles;
            period_cnt   <= '0;
          end
        end
        ST_LOAD: begin
          phase <= '0;
          if (host.stop) begin
            state        <= ST_IDLE;
            controlstate <= CS_IDLE;
            busy         <= 1'b0;
          end else begin
            state        <= ST_RUN;
            controlstate <= CS_RUN;
          end
        end
        ST_RUN: begin
          if (host.stop) begin
            state        <= ST_IDLE;
            controlstate <= CS_IDLE;
            busy         <= 1'b0;
            phase        <= '0;
          end else if (lastPhase) begin
            period_cnt <= cntSat;
            phase      <= '0;
            if (burstDone) begin
              state        <= ST_IDLE;
              controlstate <= CS_IDLE;
              busy         <= 1'b0;
              done         <= 1'b1;
            end else if (pending) begin
              // Extra LOAD clock lets the generator pick up the committed points.
              state        <= ST_LOAD;
              controlstate <= CS_LOAD;
            end
          end else begin
            phase <= phase + PW'(1);
          end
        end
        default: begin
          state        <= ST_IDLE;
          controlstate <= CS_IDLE;
          busy         <= 1'b0;
          phase        <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sig_gen_seq.sv
// Directed scoreboard bench for sig_gen_seq; build with SGSEQ_SHADOW_EN defined to
// exercise the shadowed-write behaviour instead of write rejection.
module tb_sig_gen_seq;

  logic        clk;
  logic        rst;
  logic [3:0]  controlstate;
  logic [11:0] sgDP0, sgDP1, sgDP2, sgDP3, sgDP4, sgDP5, sgDP6, sgDP7;
  logic        busy;
  logic        done;
  logic [15:0] period_cnt;
  logic [11:0] dpArr [8];

  int vectors     = 0;
  int miscompares = 0;
  int genIdx      = 0;
  bit genArm      = 0;
  logic [11:0] sbq [$];

  sig_gen_seq_if #(.DW(12), .CW(16)) hostIf ();

  sig_gen_seq #(.DW(12), .CW(16), .PERIOD_CLKS(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .host        (hostIf.slave),
    .controlstate(controlstate),
    .sgDP0       (sgDP0),
    .sgDP1       (sgDP1),
    .sgDP2       (sgDP2),
    .sgDP3       (sgDP3),
    .sgDP4       (sgDP4),
    .sgDP5       (sgDP5),
    .sgDP6       (sgDP6),
    .sgDP7       (sgDP7),
    .busy        (busy),
    .done        (done),
    .period_cnt  (period_cnt)
  );

  assign dpArr[0] = sgDP0;
  assign dpArr[1] = sgDP1;
  assign dpArr[2] = sgDP2;
  assign dpArr[3] = sgDP3;
  assign dpArr[4] = sgDP4;
  assign dpArr[5] = sgDP5;
  assign dpArr[6] = sgDP6;
  assign dpArr[7] = sgDP7;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Generator model: on negedge in RUN it outputs the point at its own index.
  always @(negedge clk) begin
    if (controlstate === 4'h0) begin
      genIdx = 0;
    end else if (controlstate === 4'h7) begin
      if (genArm) begin
        chk("sb_depth", (sbq.size() > 0) ? 32'd1 : 32'd0, 32'd1);
        if (sbq.size() > 0)
          chk("gen_point", dpArr[genIdx], sbq.pop_front());
      end
      genIdx = (genIdx + 1) % 8;
    end
  end

  initial begin
    bit found;
    rst = 1'b1;
    hostIf.wr_en   = 1'b0;
    hostIf.wr_addr = 3'd0;
    hostIf.wr_data = 12'h000;
    hostIf.start   = 1'b0;
    hostIf.stop    = 1'b0;
    hostIf.cycles  = 16'd0;
    repeat (2) tick();
    chk("rst_cs", controlstate, 4'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pcnt", period_cnt, 16'd0);
    chk("rst_werr", hostIf.wr_err, 1'b0);
    rst = 1'b0;
    tick();
    $display("reset released at %0t", $time);

    // T2: load ramp points, two-period burst.
    for (int i = 0; i < 8; i++) begin
      hostIf.wr_en   = 1'b1;
      hostIf.wr_addr = 3'(i);
      hostIf.wr_data = 12'(i * 256);
      tick();
    end
    hostIf.wr_en = 1'b0;
    for (int i = 0; i < 8; i++) chk("pt_write", dpArr[i], 12'(i * 256));
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < 8; i++) sbq.push_back(12'(i * 256));
    genArm = 1'b1;
    hostIf.cycles = 16'd2;
    hostIf.start  = 1'b1;
    tick();
    hostIf.start = 1'b0;
    chk("t2_load_cs", controlstate, 4'h5);
    chk("t2_load_busy", busy, 1'b1);
    tick();
    for (int k = 0; k < 16; k++) begin
      chk("t2_run_cs", controlstate, 4'h7);
      chk("t2_run_done", done, 1'b0);
      tick();
    end
    chk("t2_end_cs", controlstate, 4'h0);
    chk("t2_done", done, 1'b1);
    chk("t2_pcnt", period_cnt, 16'd2);
    chk("t2_busy", busy, 1'b0);
    tick();
    chk("t2_done_1clk", done, 1'b0);
    genArm = 1'b0;
    chk("t2_sb_drained", sbq.size(), 0);
    $display("T2 two-period burst finished at %0t", $time);

    // T3: continuous run aborted by stop after 100 RUN clocks.
    hostIf.cycles = 16'd0;
    hostIf.start  = 1'b1;
    tick();
    hostIf.start = 1'b0;
    tick();
    repeat (100) tick();
    chk("t3_run_cs", controlstate, 4'h7);
    chk("t3_pre_pcnt", period_cnt, 16'(100 / 8));
    hostIf.stop = 1'b1;
    tick();
    hostIf.stop = 1'b0;
    chk("t3_stop_cs", controlstate, 4'h0);
    chk("t3_stop_done", done, 1'b0);
    chk("t3_pcnt", period_cnt, 16'd12);
    chk("t3_busy", busy, 1'b0);
    $display("T3 continuous run stopped at %0t", $time);

    // T4: write coincident with start, then start+stop.
    tick();
    hostIf.start   = 1'b1;
    hostIf.wr_en   = 1'b1;
    hostIf.wr_addr = 3'd3;
    hostIf.wr_data = 12'hABC;
    tick();
    hostIf.start = 1'b0;
    hostIf.wr_en = 1'b0;
    chk("t4_load_cs", controlstate, 4'h5);
    chk("t4_dp3", sgDP3, 12'hABC);
    hostIf.stop = 1'b1;
    tick();
    hostIf.stop = 1'b0;
    chk("t4_stop_load", controlstate, 4'h0);
    hostIf.start = 1'b1;
    hostIf.stop  = 1'b1;
    tick();
    hostIf.start = 1'b0;
    hostIf.stop  = 1'b0;
    chk("t4_startstop_cs", controlstate, 4'h0);
    tick();
    chk("t4_still_idle", controlstate, 4'h0);
    $display("T4 coincident start cases done at %0t", $time);

    // T5: write during RUN.
    hostIf.cycles = 16'd3;
    hostIf.start  = 1'b1;
    tick();
    hostIf.start = 1'b0;
    tick();
    tick();
    hostIf.wr_en   = 1'b1;
    hostIf.wr_addr = 3'd0;
    hostIf.wr_data = 12'hFFF;
    tick();
    hostIf.wr_en = 1'b0;
`ifdef SGSEQ_SHADOW_EN
    chk("t5_werr", hostIf.wr_err, 1'b0);
    chk("t5_dp0_held", sgDP0, 12'h000);
    repeat (5) tick();
    chk("t5_phase7_cs", controlstate, 4'h7);
    tick();
    chk("t5_ins_load", controlstate, 4'h5);
    chk("t5_dp0_commit", sgDP0, 12'hFFF);
    chk("t5_ins_pcnt", period_cnt, 16'd1);
    tick();
    chk("t5_resume_cs", controlstate, 4'h7);
`else
    chk("t5_werr", hostIf.wr_err, 1'b1);
    chk("t5_dp0_held", sgDP0, 12'h000);
    tick();
    chk("t5_werr_1clk", hostIf.wr_err, 1'b0);
`endif
    found = 1'b0;
    for (int n = 0; n < 60 && !found; n++) begin
      tick();
      if (controlstate === 4'h0) found = 1'b1;
    end
    chk("t5_complete", found, 1'b1);
    chk("t5_done", done, 1'b1);
    chk("t5_pcnt", period_cnt, 16'd3);
    $display("T5 write during RUN done at %0t", $time);

    // T1: asynchronous reset mid-RUN.
    hostIf.cycles = 16'd0;
    hostIf.start  = 1'b1;
    tick();
    hostIf.start = 1'b0;
    tick();
    tick();
    chk("t1_pre_cs", controlstate, 4'h7);
    #2 rst = 1'b1;
    #1;
    chk("t1_cs", controlstate, 4'h0);
    chk("t1_busy", busy, 1'b0);
    chk("t1_pcnt", period_cnt, 16'd0);
    for (int i = 0; i < 8; i++) chk("t1_dp", dpArr[i], 12'h000);
    #3 rst = 1'b0;
    tick();
    tick();
    chk("t1_post_cs", controlstate, 4'h0);
    chk("t1_post_busy", busy, 1'b0);
    $display("T1 async reset done at %0t", $time);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
